// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Hunts for header/length/payload/checksum frames in the UART driver's
//   receive byte stream. It buffers and verifies each frame, then streams the
//   payload out over a valid/ready interface. A bad frame raises an error pulse
//   with a code and emits no payload.
//
//   Optional build macro: UART_PARSER_TIMEOUT_EN. When it is defined, an
//   inter-byte idle counter aborts a partial frame with error code 3.
//
// Ports
//   clock        baud-rate user clock from the UART driver
//   reset        asynchronous, active-high reset
//   i_rx_data    received byte
//   i_rx_valid   receive valid level; a rising edge marks one new byte
//   o_pl_data    payload byte
//   o_pl_valid   payload byte valid
//   i_pl_ready   downstream ready
//   o_pl_last    final payload byte of the frame
//   o_pl_len     payload length of the frame being streamed
//   o_err_valid  one-cycle error pulse
//   o_err_code   1 bad length, 2 checksum mismatch, 3 timeout (held)
//   o_drop       one-cycle pulse when a byte arrives while streaming
//   o_busy       high whenever the parser is not idle
module uart_frame_parser #(
    parameter logic [7:0]  P_HEADER      = 8'hA5,
    parameter int unsigned P_MAX_LEN     = 16,
    parameter int unsigned P_TIMEOUT_CYC = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_pl_data,
    output logic       o_pl_valid,
    input  logic       i_pl_ready,
    output logic       o_pl_last,
    output logic [7:0] o_pl_len,
    output logic       o_err_valid,
    output logic [1:0] o_err_code,
    output logic       o_drop,
    output logic       o_busy
);

    localparam int unsigned IW     = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
    localparam logic [7:0]  MaxLen = 8'(P_MAX_LEN);

    typedef enum logic [2:0] {StIdle, StLen, StPayload, StChk, StOut} state_e;

    state_e     state_q;
    logic       rx_valid_q;
    logic       accept;
    logic       timeout;
    logic [7:0] len_q;
    logic [7:0] csum_q;
    logic [7:0] wr_idx_q;
    logic [7:0] rd_idx_q;
    logic [7:0] rd_nxt;
    logic [7:0] buf_q [2**IW];

    // The driver holds valid for several cycles per byte; only its rising edge counts.
    assign accept = i_rx_valid & ~rx_valid_q;
    assign rd_nxt = rd_idx_q + 8'd1;
    assign o_busy = (state_q != StIdle);

`ifdef UART_PARSER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(P_TIMEOUT_CYC + 1);

    logic [TW-1:0] idle_cnt_q;
    logic          armed;

    assign armed   = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
    // An accepted byte in the expiring cycle wins over the timeout.
    assign timeout = armed && !accept && (idle_cnt_q == TW'(P_TIMEOUT_CYC - 1));

    // Every entry into an armed state is caused by an accepted byte, so clearing
    // on accept also clears on entry. Outside the armed states the count is frozen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else if (accept || timeout) begin
            idle_cnt_q <= '0;
        end else if (armed) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Payload storage. It has no reset because its contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (state_q == StPayload && accept) begin
            buf_q[wr_idx_q[IW-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rx_valid_q  <= 1'b0;
            len_q       <= '0;
            csum_q      <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            o_pl_data   <= '0;
            o_pl_valid  <= 1'b0;
            o_pl_last   <= 1'b0;
            o_pl_len    <= '0;
            o_err_valid <= 1'b0;
            o_err_code  <= '0;
            o_drop      <= 1'b0;
        end else begin
            rx_valid_q  <= i_rx_valid;
            o_err_valid <= 1'b0;
            o_drop      <= 1'b0;
            if (timeout) begin
                o_err_valid <= 1'b1;
                o_err_code  <= 2'd3;
                state_q     <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept && i_rx_data == P_HEADER) begin
                            state_q <= StLen;
                        end
                    end
                    StLen: begin
                        if (accept) begin
                            if (i_rx_data == 8'd0 || i_rx_data > MaxLen) begin
                                o_err_valid <= 1'b1;
                                o_err_code  <= 2'd1;
                                state_q     <= StIdle;
                            end else begin
                                len_q    <= i_rx_data;
                                csum_q   <= i_rx_data;
                                wr_idx_q <= '0;
                                state_q  <= StPayload;
                            end
                        end
                    end
                    StPayload: begin
                        if (accept) begin
                            csum_q   <= csum_q + i_rx_data;
                            wr_idx_q <= wr_idx_q + 8'd1;
                            if (wr_idx_q + 8'd1 == len_q) begin
                                state_q <= StChk;
                            end
                        end
                    end
                    StChk: begin
                        if (accept) begin
                            if (i_rx_data == csum_q) begin
                                rd_idx_q <= '0;
                                state_q  <= StOut;
                            end else begin
                                o_err_valid <= 1'b1;
                                o_err_code  <= 2'd2;
                                state_q     <= StIdle;
                            end
                        end
                    end
                    StOut: begin
                        if (accept) begin
                            o_drop <= 1'b1;
                        end
                        // The first OUT cycle loads the output registers. Later
                        // cycles only advance when a handshake happens.
                        if (!o_pl_valid) begin
                            o_pl_valid <= 1'b1;
                            o_pl_data  <= buf_q[rd_idx_q[IW-1:0]];
                            o_pl_last  <= (rd_idx_q == len_q - 8'd1);
                            o_pl_len   <= len_q;
                        end else if (i_pl_ready) begin
                            if (o_pl_last) begin
                                o_pl_valid <= 1'b0;
                                o_pl_last  <= 1'b0;
                                state_q    <= StIdle;
                            end else begin
                                rd_idx_q  <= rd_nxt;
                                o_pl_data <= buf_q[rd_nxt[IW-1:0]];
                                o_pl_last <= (rd_nxt == len_q - 8'd1);
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_valid = 1'b0;
    logic [7:0] o_pl_data;
    logic       o_pl_valid;
    logic       i_pl_ready = 1'b0;
    logic       o_pl_last;
    logic [7:0] o_pl_len;
    logic       o_err_valid;
    logic [1:0] o_err_code;
    logic       o_drop;
    logic       o_busy;

    uart_frame_parser dut (
        .clock       (clock),
        .reset       (reset),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_pl_data   (o_pl_data),
        .o_pl_valid  (o_pl_valid),
        .i_pl_ready  (i_pl_ready),
        .o_pl_last   (o_pl_last),
        .o_pl_len    (o_pl_len),
        .o_err_valid (o_err_valid),
        .o_err_code  (o_err_code),
        .o_drop      (o_drop),
        .o_busy      (o_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    bit rmode    = 1'b0;  // 1: randomise i_pl_ready every cycle

    // Scoreboard queues: expected from the frame model, observed from the monitor.
    logic [7:0] exp_data[$];
    logic       exp_last[$];
    logic [7:0] exp_len[$];
    logic [1:0] exp_err[$];
    int         exp_drop = 0;
    logic [7:0] obs_data[$];
    logic       obs_last[$];
    logic [7:0] obs_len[$];
    logic [1:0] obs_err[$];
    int         obs_drop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge, away from the active edge.
    logic       hold_q = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    logic [7:0] held_len;
    always @(negedge clock) begin
        if (reset) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("stall_valid", 32'(o_pl_valid), 32'd1);
                check("stall_data", 32'(o_pl_data), 32'(held_data));
                check("stall_last", 32'(o_pl_last), 32'(held_last));
                check("stall_len", 32'(o_pl_len), 32'(held_len));
            end
            if (o_pl_valid && i_pl_ready) begin
                obs_data.push_back(o_pl_data);
                obs_last.push_back(o_pl_last);
                obs_len.push_back(o_pl_len);
            end
            if (o_err_valid) obs_err.push_back(o_err_code);
            if (o_drop) obs_drop++;
            hold_q    = o_pl_valid && !i_pl_ready;
            held_data = o_pl_data;
            held_last = o_pl_last;
            held_len  = o_pl_len;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rmode) i_pl_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        repeat (hold) step();
        i_rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_bytes(input logic [7:0] fr[$], input bit rnd);
        foreach (fr[i]) begin
            send_byte(fr[i], rnd ? $urandom_range(1, 3) : 1, rnd ? $urandom_range(1, 2) : 1);
        end
    endtask

    // Frame-level reference: the frame must begin with the header while the parser is idle.
    task automatic model_frame(input logic [7:0] fr[$]);
        int         len;
        logic [7:0] sum;
        len = int'(fr[1]);
        if (len == 0 || len > 16) begin
            exp_err.push_back(2'd1);
            return;
        end
        sum = fr[1];
        for (int i = 0; i < len; i++) sum = sum + fr[2 + i];
        if (fr[2 + len] != sum) begin
            exp_err.push_back(2'd2);
            return;
        end
        for (int i = 0; i < len; i++) begin
            exp_data.push_back(fr[2 + i]);
            exp_last.push_back(i == len - 1);
            exp_len.push_back(fr[1]);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 2000) begin
            step();
            n++;
        end
        check("idle_wait", 32'(o_busy), 32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_pl_valid && n < 50) begin
            step();
            n++;
        end
        check("valid_wait", 32'(o_pl_valid), 32'd1);
    endtask

    task automatic compare(input string tag);
        wait_idle();
        repeat (3) step();
        check({tag, "_npl"}, 32'(obs_data.size()), 32'(exp_data.size()));
        check({tag, "_nerr"}, 32'(obs_err.size()), 32'(exp_err.size()));
        check({tag, "_drops"}, 32'(obs_drop), 32'(exp_drop));
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            check({tag, "_data"}, 32'(obs_data[i]), 32'(exp_data[i]));
            check({tag, "_last"}, 32'(obs_last[i]), 32'(exp_last[i]));
            check({tag, "_len"}, 32'(obs_len[i]), 32'(exp_len[i]));
        end
        for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) begin
            check({tag, "_code"}, 32'(obs_err[i]), 32'(exp_err[i]));
        end
        exp_data.delete(); exp_last.delete(); exp_len.delete(); exp_err.delete();
        obs_data.delete(); obs_last.delete(); obs_len.delete(); obs_err.delete();
        exp_drop = 0;
        obs_drop = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pl_valid"}, 32'(o_pl_valid), 32'd0);
        check({tag, "_pl_data"}, 32'(o_pl_data), 32'd0);
        check({tag, "_pl_last"}, 32'(o_pl_last), 32'd0);
        check({tag, "_pl_len"}, 32'(o_pl_len), 32'd0);
        check({tag, "_err_valid"}, 32'(o_err_valid), 32'd0);
        check({tag, "_err_code"}, 32'(o_err_code), 32'd0);
        check({tag, "_drop"}, 32'(o_drop), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] sum;
        int         len;

        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // 1: good frame with ready high, plus the output latency.
        i_pl_ready = 1'b1;
        fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        model_frame(fr);
        for (int i = 0; i < 5; i++) send_byte(fr[i], 1, 1);
        i_rx_data  = 8'h69;
        i_rx_valid = 1'b1;
        step();
        check("lat_first_edge", 32'(o_pl_valid), 32'd0);
        i_rx_valid = 1'b0;
        step();
        check("lat_second_edge", 32'(o_pl_valid), 32'd1);
        check("t1_b0", 32'(o_pl_data), 32'h11);
        step();
        check("t1_b1", 32'(o_pl_data), 32'h22);
        step();
        check("t1_b2", 32'(o_pl_data), 32'h33);
        check("t1_b2_last", 32'(o_pl_last), 32'd1);
        compare("good");

        // 2: backpressure pattern.
        i_pl_ready = 1'b0;
        model_frame(fr);
        send_bytes(fr, 1'b0);
        wait_valid();
        begin
            logic [5:0] pat;
            pat = 6'b110010;  // applied LSB first: 0,1,0,0,1,1
            for (int i = 0; i < 6; i++) begin
                i_pl_ready = pat[i];
                step();
            end
        end
        check("bp_busy_after_last", 32'(o_busy), 32'd0);
        check("bp_valid_after_last", 32'(o_pl_valid), 32'd0);
        compare("bp");

        // 3: bad checksum, then two bad lengths.
        i_pl_ready = 1'b1;
        fr = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        model_frame(fr);
        send_bytes(fr, 1'b0);
        compare("badsum");
        fr = '{8'hA5, 8'h00};
        model_frame(fr);
        send_bytes(fr, 1'b0);
        fr = '{8'hA5, 8'h11};
        model_frame(fr);
        send_bytes(fr, 1'b0);
        compare("badlen");
        check("err_code_held", 32'(o_err_code), 32'd1);

        // 4: garbage, then a byte dropped while stalled in OUT.
        i_pl_ready = 1'b0;
        send_byte(8'h00, 1, 1);
        send_byte(8'hFF, 1, 1);
        fr = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        model_frame(fr);
        send_bytes(fr, 1'b0);
        wait_valid();
        send_byte(8'hA5, 1, 2);
        exp_drop = 1;
        i_pl_ready = 1'b1;
        compare("drop");
        fr = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
        model_frame(fr);
        send_bytes(fr, 1'b0);
        compare("after_drop");

        // 5A: a header held for five cycles counts as one byte.
        send_byte(8'hA5, 5, 1);
        fr = '{8'hA5, 8'h01, 8'h77, 8'h78};
        model_frame(fr);
        send_byte(8'h01, 1, 1);
        send_byte(8'h77, 1, 1);
        send_byte(8'h78, 1, 1);
        compare("held");

        // 5B: reset during PAYLOAD abandons the frame silently.
        fr = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_bytes(fr, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        step();
        reset = 1'b0;
        step();
        compare("midreset");
        fr = '{8'hA5, 8'h01, 8'h33, 8'h34};
        model_frame(fr);
        send_bytes(fr, 1'b0);
        compare("post_reset");

        // 6: inter-byte silence.
        send_bytes('{8'hA5, 8'h04, 8'h01}, 1'b0);
        repeat (70) step();
`ifdef UART_PARSER_TIMEOUT_EN
        exp_err.push_back(2'd3);
        check("timeout_idle", 32'(o_busy), 32'd0);
        compare("timeout");
`else
        check("no_timeout_busy", 32'(o_busy), 32'd1);
        model_frame('{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E});
        send_bytes('{8'h02, 8'h03, 8'h04, 8'h0E}, 1'b0);
        compare("no_timeout");
`endif

        // Randomised frames with random pacing and backpressure.
        rmode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] g;
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 1, 1);
            end
            if ($urandom_range(0, 9) == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
            end else begin
                len = $urandom_range(1, 16);
            end
            fr = '{8'hA5, 8'(len)};
            if (len >= 1 && len <= 16) begin
                sum = 8'(len);
                for (int i = 0; i < len; i++) begin
                    fr.push_back(8'($urandom_range(0, 255)));
                    sum = sum + fr[2 + i];
                end
                if ($urandom_range(0, 5) == 0) sum = sum + 8'($urandom_range(1, 255));
                fr.push_back(sum);
            end
            model_frame(fr);
            send_bytes(fr, 1'b1);
            compare("rand");
        end
        rmode = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
